mul_share_arbiter: RTL and testbench
====================================

// Module: mul_share_arbiter
// PURPOSE
//  Shares one non-stallable pipelined WxW multiplier core among N requesters.
//  - Each cycle, grants at most one requester, round-robin, and drives that
//    requester's operands into the core.
//  - Tracks requester ID and valid through a MUL_LAT-deep tag pipeline.
//  - Returns each product with its ID. Sits between client blocks and the core.
// PARAMETERS
//  N        4    number of requesters (>=2)
//  W        4    operand width; product width is 2*W
//  IDW      2    requester ID width; must equal clog2(N)
//  MUL_LAT  4    core latency: mul_y at edge k+MUL_LAT matches operands captured at edge k
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        asynchronous reset, active-high
//  req_valid   in   N        requester i has an operand pair pending
//  req_ready   out  N        one-hot grant; a transfer happens when req_valid[i] & req_ready[i]
//  req_a       in   N*W      operand A, requester i in bits [i*W +: W]
//  req_b       in   N*W      operand B, same packing
//  hold        in   1        1 = issue no new grants; in-flight results still drain
//  mul_a       out  W        operand A to the core
//  mul_b       out  W        operand B to the core
//  mul_y       in   2*W      product from the core
//  rsp_valid   out  1        rsp_id and rsp_y are valid this cycle
//  rsp_id      out  IDW      requester that owns rsp_y
//  rsp_y       out  2*W      product; equals mul_y
//  busy        out  1        1 when any tag-pipeline stage is valid
// BEHAVIOUR
//  - Reset (asynchronous, immediate):
//    - all tag-pipeline valid bits cleared; rsp_valid=0, busy=0;
//    - RR pointer set to N-1, so requester 0 has top priority first.
//    - Reset mid-operation discards every in-flight result; none is ever emitted.
//  - Grant (combinational):
//    - if hold=0 and any req_valid is set, req_ready = one-hot of the first set
//      req_valid, searching from ptr+1 upward and wrapping at N-1 -> 0;
//    - otherwise req_ready = 0.
//    - req_ready depends on req_valid. Requesters must not make req_valid
//      depend on req_ready.
//  - Operands:
//    - on a grant, mul_a/mul_b = the granted requester's req_a/req_b;
//    - with no grant, both are 0.
//  - Pointer: on a grant, ptr <= granted index at the edge; otherwise it holds.
//  - Tag pipeline:
//    - MUL_LAT stages of {valid, id}, shifted every cycle with no stall.
//    - Stage 0 loads {|req_ready, granted id}.
//    - rsp_valid/rsp_id come from the last stage; rsp_y = mul_y.
//    - Latency is exactly MUL_LAT cycles from transfer to rsp_valid.
//    - Throughput is 1 result per cycle.
//  - Response: no backpressure on the response side; consumers must accept
//    rsp_valid every cycle.
//  - hold: asserting hold mid-stream drops no results. busy falls exactly
//    MUL_LAT cycles after the last grant.
//  - Fairness: with all N requesters valid continuously, grants cycle
//    0,1,..,N-1,0. No requester waits more than N-1 cycles after others are served.
//  - Simultaneous events: the requester at ptr+1 wins. A requester that
//    deasserts req_valid is skipped in the same cycle.
//  - Arithmetic: the arbiter never alters operands or products. Width
//    handling is the core's responsibility.
// CONFIGURATION
//  MUL_ARB_STATS_EN defined:
//   - adds input stat_clr (1 bit) and output stat_grants (N*16 bits).
//   - stat_grants holds one 16-bit saturating grant counter per requester i,
//     at bits [i*16 +: 16].
//   - A counter increments on each transfer of its requester and sticks at 16'hFFFF.
//   - stat_clr zeroes all counters synchronously and wins over a same-cycle
//     increment.
//   - rst clears all counters.
//  MUL_ARB_STATS_EN undefined:
//   - stat_clr, stat_grants and the counters do not exist;
//   - all other behaviour is identical.
// TESTING (N=4, W=4, MUL_LAT=4; model the core as registered a*b with 4-cycle delay)
//  1. Single: req 2 valid with A=3, B=5 for one cycle -> req_ready=4'b0100 that
//     cycle; 4 cycles later rsp_valid=1, rsp_id=2, rsp_y=8'd15.
//  2. All four valid for 8 cycles, A=i+1, B=15 -> grant order 0,1,2,3,0,1,2,3;
//     rsp_y sequence 15,30,45,60,... with matching IDs, back-to-back.
//  3. Reqs 1 and 3 valid, ptr=1 -> 3 is granted, then 1, alternating.
//     A requester that drops valid is skipped.
//  4. hold=1 during a stream of 2 grants -> req_ready=0 while hold=1.
//     Both pending results still emerge; busy=0 4 cycles after the last grant.
//  5. rst pulsed 2 cycles after 3 grants -> rsp_valid stays 0 afterward, busy=0.
//     The next grant goes to requester 0.
//  6. (MUL_ARB_STATS_EN) 70000 grants to req 0 -> stat_grants[15:0]=16'hFFFF.
//     stat_clr with a same-cycle grant -> counter reads 0.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Round-robin share of one non-stallable pipelined multiplier among N clients.
// Define MUL_ARB_STATS_EN to add per-requester saturating grant counters.
module mul_share_arbiter #(
  parameter int N       = 4,
  parameter int W       = 4,
  parameter int IDW     = 2,
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  input  logic             hold,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [2*W-1:0]   mul_y,
  output logic             rsp_valid,
  output logic [IDW-1:0]   rsp_id,
  output logic [2*W-1:0]   rsp_y,
  output logic             busy
`ifdef MUL_ARB_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [N*16-1:0]  stat_grants
`endif
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_id;
  logic           gnt;

  logic [MUL_LAT-1:0] tag_v;
  logic [IDW-1:0]     tag_id [MUL_LAT];

  // First valid requester strictly after ptr, wrapping; ptr itself comes last.
  always_comb begin
    int idx;
    idx    = 0;
    gnt    = 1'b0;
    gnt_id = '0;
    if (!hold) begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!gnt && req_valid[idx]) begin
          gnt    = 1'b1;
          gnt_id = IDW'(idx);
        end
      end
    end
  end

  assign req_ready = gnt ? (N'(1) << gnt_id) : '0;
  assign mul_a     = gnt ? req_a[gnt_id*W +: W] : '0;
  assign mul_b     = gnt ? req_b[gnt_id*W +: W] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IDW'(N - 1);
    end else if (gnt) begin
      ptr <= gnt_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < MUL_LAT; s++) begin
        tag_v[s]  <= 1'b0;
        tag_id[s] <= '0;
      end
    end else begin
      tag_v[0]  <= gnt;
      tag_id[0] <= gnt_id;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  assign rsp_valid = tag_v[MUL_LAT-1];
  assign rsp_id    = tag_id[MUL_LAT-1];
  assign rsp_y     = mul_y;
  assign busy      = |tag_v;

`ifdef MUL_ARB_STATS_EN
  logic [15:0] cnt [N];

  // Clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else if (gnt && cnt[gnt_id] != 16'hFFFF) begin
      cnt[gnt_id] <= cnt[gnt_id] + 16'd1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_stat
    assign stat_grants[i*16 +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter (N=4, W=4, MUL_LAT=4).
// Core modelled as a 4-stage registered a*b pipeline.
module tb_mul_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [15:0] req_a, req_b;
  logic        hold = 1'b0;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_y;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_y;
  logic        busy;
`ifdef MUL_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [63:0] stat_grants;
`endif

  logic [3:0] a [4];
  logic [3:0] b [4];
  logic [7:0] core_p [4];

  int vec  = 0;
  int errs = 0;

  assign req_a = {a[3], a[2], a[1], a[0]};
  assign req_b = {b[3], b[2], b[1], b[0]};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    core_p[0] <= mul_a * mul_b;
    for (int i = 1; i < 4; i++) core_p[i] <= core_p[i-1];
  end
  assign mul_y = core_p[3];

  mul_share_arbiter #(.N(4), .W(4), .IDW(2), .MUL_LAT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .hold      (hold),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_y     (mul_y),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .busy      (busy)
`ifdef MUL_ARB_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_grants (stat_grants)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    hold      = 1'b0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    rst       = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    vec++;
    if (rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
    end
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    vec++;
    if (req_ready !== 4'b0001) begin
      errs++;
      $display("FAIL reset_ptr_ready: got %b want 0001", req_ready);
    end
    step();
    rst       = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    a[2] = 4'd3;
    b[2] = 4'd5;
    req_valid = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vec++;
      if (req_ready !== (c == 0 ? 4'b0100 : 4'b0000)) begin
        errs++;
        $display("FAIL single_ready c%0d: got %b", c, req_ready);
      end
      if (c == 0) begin
        vec++;
        if (mul_a !== 4'd3 || mul_b !== 4'd5) begin
          errs++;
          $display("FAIL single_ops: got %0d,%0d want 3,5", mul_a, mul_b);
        end
      end
      vec++;
      if (rsp_valid !== (c == 4)) begin
        errs++;
        $display("FAIL single_rsp_valid c%0d: got %b", c, rsp_valid);
      end
      if (c == 4) begin
        vec++;
        if (rsp_id !== 2'd2 || rsp_y !== 8'd15) begin
          errs++;
          $display("FAIL single_rsp: got id %0d y %0d want 2,15", rsp_id, rsp_y);
        end
      end
      if (c == 5) begin
        vec++;
        if (busy !== 1'b0) begin
          errs++;
          $display("FAIL single_busy: got %b want 0", busy);
        end
      end
      step();
      req_valid = '0;
    end
  endtask

  task automatic test_all_four();
    int g;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a[i] = 4'(i + 1);
      b[i] = 4'd15;
    end
    for (int c = 0; c < 13; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      if (c < 8) begin
        g = c % 4;
        vec++;
        if (req_ready !== 4'(1 << g) || mul_a !== 4'(g + 1)) begin
          errs++;
          $display("FAIL all4_grant c%0d: got %b a=%0d want id %0d", c, req_ready, mul_a, g);
        end
      end
      if (c >= 4) begin
        vec++;
        if (rsp_valid !== (c < 12)) begin
          errs++;
          $display("FAIL all4_rsp_valid c%0d: got %b", c, rsp_valid);
        end
        if (c < 12) begin
          g = (c - 4) % 4;
          vec++;
          if (rsp_id !== 2'(g) || rsp_y !== 8'((g + 1) * 15)) begin
            errs++;
            $display("FAIL all4_rsp c%0d: got id %0d y %0d want %0d,%0d",
                     c, rsp_id, rsp_y, g, (g + 1) * 15);
          end
        end
      end
      step();
    end
  endtask

  task automatic test_rr_skip();
    logic [3:0] vt  [7];
    logic [3:0] rdy [7];
    logic [1:0] rid [7];
    logic [7:0] ry  [7];
    vt  = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b0010, 4'b1000, 4'b1100};
    rdy = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0100};
    rid = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd2};
    ry  = '{8'd6, 8'd20, 8'd6, 8'd20, 8'd6, 8'd20, 8'd12};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a[i] = 4'(i + 2);
      b[i] = 4'(i + 1);
    end
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 7) ? vt[c] : 4'b0000;
      @(negedge clk);
      if (c < 7) begin
        vec++;
        if (req_ready !== rdy[c]) begin
          errs++;
          $display("FAIL rr_ready c%0d: got %b want %b", c, req_ready, rdy[c]);
        end
      end
      if (c >= 4) begin
        vec++;
        if (rsp_valid !== (c < 11)) begin
          errs++;
          $display("FAIL rr_rsp_valid c%0d: got %b", c, rsp_valid);
        end
        if (c < 11) begin
          vec++;
          if (rsp_id !== rid[c-4] || rsp_y !== ry[c-4]) begin
            errs++;
            $display("FAIL rr_rsp c%0d: got id %0d y %0d want %0d,%0d",
                     c, rsp_id, rsp_y, rid[c-4], ry[c-4]);
          end
        end
      end
      step();
    end
  endtask

  task automatic test_hold();
    logic [3:0] rdy [8];
    rdy = '{4'b0001, 4'b0010, 4'b0000, 4'b0000,
            4'b0000, 4'b0000, 4'b0000, 4'b0001};
    do_reset();
    a[0] = 4'd7;
    b[0] = 4'd9;
    a[1] = 4'd15;
    b[1] = 4'd15;
    req_valid = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      hold = (c >= 2 && c <= 6);
      @(negedge clk);
      vec++;
      if (req_ready !== rdy[c]) begin
        errs++;
        $display("FAIL hold_ready c%0d: got %b want %b", c, req_ready, rdy[c]);
      end
      if (c >= 1) begin
        vec++;
        if (rsp_valid !== (c == 4 || c == 5)) begin
          errs++;
          $display("FAIL hold_rsp_valid c%0d: got %b", c, rsp_valid);
        end
      end
      if (c == 4) begin
        vec++;
        if (rsp_id !== 2'd0 || rsp_y !== 8'd63) begin
          errs++;
          $display("FAIL hold_rsp0: got id %0d y %0d want 0,63", rsp_id, rsp_y);
        end
      end
      if (c == 5) begin
        vec++;
        if (rsp_id !== 2'd1 || rsp_y !== 8'd225 || busy !== 1'b1) begin
          errs++;
          $display("FAIL hold_rsp1: got id %0d y %0d busy %b want 1,225,1",
                   rsp_id, rsp_y, busy);
        end
      end
      if (c == 6) begin
        vec++;
        if (busy !== 1'b0) begin
          errs++;
          $display("FAIL hold_busy: got %b want 0", busy);
        end
      end
      step();
    end
    hold      = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a[i] = 4'(i + 1);
      b[i] = 4'd3;
    end
    for (int c = 0; c < 11; c++) begin
      req_valid = (c < 3 || c == 10) ? 4'b1111 : 4'b0000;
      rst       = (c == 4);
      @(negedge clk);
      if (c < 3) begin
        vec++;
        if (req_ready !== 4'(1 << c)) begin
          errs++;
          $display("FAIL rmid_grant c%0d: got %b", c, req_ready);
        end
      end
      if (c >= 4 && c < 10) begin
        vec++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
          errs++;
          $display("FAIL rmid_flush c%0d: got valid %b busy %b want 0,0",
                   c, rsp_valid, busy);
        end
      end
      if (c == 10) begin
        vec++;
        if (req_ready !== 4'b0001) begin
          errs++;
          $display("FAIL rmid_ptr: got %b want 0001", req_ready);
        end
      end
      step();
    end
    rst       = 1'b0;
    req_valid = '0;
  endtask

`ifdef MUL_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    req_valid = 4'b0001;
    repeat (3) step();
    req_valid = '0;
    @(negedge clk);
    vec++;
    if (stat_grants[15:0] !== 16'd3 || stat_grants[31:16] !== 16'd0) begin
      errs++;
      $display("FAIL stat_count: got %h,%h want 0003,0000",
               stat_grants[15:0], stat_grants[31:16]);
    end
    step();
    req_valid = 4'b0001;
    repeat (70000) @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    vec++;
    if (stat_grants[15:0] !== 16'hFFFF) begin
      errs++;
      $display("FAIL stat_sat: got %h want ffff", stat_grants[15:0]);
    end
    step();
    req_valid = 4'b0001;
    stat_clr  = 1'b1;
    step();
    req_valid = '0;
    stat_clr  = 1'b0;
    @(negedge clk);
    vec++;
    if (stat_grants[15:0] !== 16'd0) begin
      errs++;
      $display("FAIL stat_clr: got %h want 0000", stat_grants[15:0]);
    end
    step();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_rr_skip();
    test_hold();
    test_reset_mid();
`ifdef MUL_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
